sync_sp_memory: RTL and testbench
=================================

// Module: sync_sp_memory
// PURPOSE
//  Single-port synchronous RAM: one shared address bus, a write enable and a read enable.
//  Generic storage block for datapath buffers and scratch memories.
//  The storage array is named `mem` so benches can load and dump it by hierarchy
//  ($readmemh/$writememh on <inst>.mem).
// PARAMETERS
//  WIDTH       16   data word width in bits
//  DEPTH       128  number of words; must satisfy DEPTH <= 2**ADDR_WIDTH
//  ADDR_WIDTH  7    address width in bits
// PORTS
//  clk     in   1           single clock; all logic on posedge
//  rst     in   1           synchronous, active-high reset
//  addr    in   ADDR_WIDTH  word address, shared by read and write
//  w_data  in   WIDTH       write data
//  w_en    in   1           write enable
//  r_en    in   1           read enable
//  r_data  out  WIDTH       registered read data
//  valid   in   1           request valid (VALID_READY_EN builds only)
//  ready   out  1           block can accept a request (VALID_READY_EN builds only)
// BEHAVIOUR
//  - Storage: reg [WIDTH-1:0] mem [0:DEPTH-1]. Not cleared by reset; contents
//    survive reset and are X until written or loaded.
//  - Reset: while rst=1 at a posedge, r_data<=0 and ready<=0. Writes and reads are
//    ignored during reset.
//  - Write: at a posedge with rst=0, w_en=1 and addr<DEPTH: mem[addr]<=w_data.
//    The write completes in the same cycle.
//  - Read: at a posedge with rst=0, r_en=1 and addr<DEPTH: r_data<=mem[addr].
//    Latency is 1 cycle: data is visible after the edge that samples r_en.
//  - r_data holds its last value whenever r_en=0. There is no output enable and no
//    return to zero.
//  - Read-during-write, same cycle (w_en=r_en=1): the read is read-first.
//    r_data gets the old mem[addr]; the new value is visible on the next read.
//  - Out of range (addr>=DEPTH, only possible when DEPTH<2**ADDR_WIDTH):
//    the write is dropped and the read returns r_data<=0.
//  - Addressing: no wrap-around and no auto-increment; addr is used as given.
//  - Reset asserted in the middle of a burst: the pending cycle's access is discarded
//    and r_data goes to 0. mem keeps all completed writes.
//  - X on w_en or r_en is not guarded. Treat it as a bench error.
// CONFIGURATION
//  VALID_READY_EN defined:
//  - valid and ready ports exist.
//  - ready is registered: 0 in reset, then 1 from the first posedge after rst deasserts.
//  - A write or read takes effect only when valid && ready && (w_en|r_en) at the posedge.
//  - With valid=0, w_en and r_en are ignored and r_data holds.
//  VALID_READY_EN undefined:
//  - valid and ready ports are absent.
//  - w_en and r_en act directly as above.
// TESTING
//  - Reset: rst=1 for 2 cycles -> r_data==0 (and ready==0); after release, ready==1
//    one edge later.
//  - Front-door write then read: write random data to addr 0..127 one per cycle,
//    then r_en for 0..127.
//    -> r_data one cycle after each address equals the value written there.
//  - Front-door write, back-door check: fill 0..127, then $writememh(<inst>.mem).
//    -> the dump matches the written values.
//  - Back-door load, front-door read: $readmemh a file into <inst>.mem,
//    then read 0..127 -> r_data matches the file.
//  - Read-during-write: mem[5]=16'hAAAA; then w_en=r_en=1, addr=5, w_data=16'h5555.
//    -> r_data==16'hAAAA; the next read of 5 returns 16'h5555.
//  - Hold and reset mid-burst: after reading 16'h1234, drop r_en -> r_data stays
//    16'h1234.
//    Assert rst mid-write-burst -> r_data==0 and earlier writes are still readable
//    after release.

Source files
------------

// File: rtl/sync_sp_memory.sv
// Single-port synchronous RAM with a shared address, read-first read-during-write and 1-cycle registered read.
// Optional VALID_READY_EN adds a valid/ready request handshake; the default build omits those ports.
module sync_sp_memory #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      w_data,
  input  logic                  w_en,
  input  logic                  r_en,
  output logic [WIDTH-1:0]      r_data
`ifdef VALID_READY_EN
  ,
  input  logic                  valid,
  output logic                  ready
`endif
);

  reg [WIDTH-1:0] mem [0:DEPTH-1];

  logic [WIDTH-1:0] r_data_q, r_data_d;
  logic             acc_ok;
  logic             in_range;

  assign in_range = (32'(addr) < DEPTH);

`ifdef VALID_READY_EN
  logic ready_q;

  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign acc_ok = valid && ready_q;
  assign ready  = ready_q;
`else
  assign acc_ok = 1'b1;
`endif

  // Storage has no reset; contents survive rst and stay X until written or loaded.
  always_ff @(posedge clk) begin
    if (!rst && acc_ok && w_en && in_range) mem[addr] <= w_data;
  end

  always_comb begin
    r_data_d = r_data_q;
    if (acc_ok && r_en) r_data_d = in_range ? mem[addr] : '0;
  end

  // The nonblocking write above lands after this sample, which gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) r_data_q <= '0;
    else     r_data_q <= r_data_d;
  end

  assign r_data = r_data_q;

endmodule

// File: tb/tb_sync_sp_memory.sv
// Scoreboard bench for sync_sp_memory (default build): the driver queues the expected r_data for every
// cycle it drives, and a monitor compares each entry just after the following posedge.
module tb_sync_sp_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  addr = '0;
  logic [15:0] w_data = '0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [15:0] r_data;

  always #5 clk = ~clk;

  sync_sp_memory #(.WIDTH(16), .DEPTH(128), .ADDR_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .addr(addr), .w_data(w_data),
    .w_en(w_en), .r_en(r_en), .r_data(r_data)
  );

  typedef struct {
    logic [15:0] v;
    string       tag;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_mem [128];
  logic [15:0] exp_rd;
  int          checks = 0;
  int          errors = 0;

  // Drive one cycle and queue the r_data expected after that edge (read happens before the write).
  task automatic step(input logic r, input logic we, input logic re,
                      input logic [6:0] a, input logic [15:0] wd, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; w_en = we; r_en = re; addr = a; w_data = wd;
    if (r) exp_rd = '0;
    else begin
      if (re) exp_rd = exp_mem[a];
      if (we) exp_mem[a] = wd;
    end
    e.v = exp_rd; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (r_data !== e.v) begin
          errors++;
          $display("FAIL %s: r_data=%h expected=%h at %0t", e.tag, r_data, e.v, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset held for two cycles; r_data must read 0.
    step(1, 0, 0, 7'd0, 16'h0, "reset");
    step(1, 0, 0, 7'd0, 16'h0, "reset");

    // Front-door fill; r_data holds 0 since no reads are issued.
    for (int i = 0; i < 128; i++)
      step(0, 1, 0, 7'(i), 16'($urandom), "fill_hold");
    drain();

    // Back-door check of the filled array.
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (dut.mem[i] !== exp_mem[i]) begin
        errors++;
        $display("FAIL backdoor_dump[%0d]: mem=%h expected=%h", i, dut.mem[i], exp_mem[i]);
      end
    end

    // Front-door readback of the fill.
    for (int i = 0; i < 128; i++)
      step(0, 0, 1, 7'(i), 16'h0, "fd_read");
    drain();

    // Back-door load, then front-door read.
    for (int i = 0; i < 128; i++) begin
      dut.mem[i] = 16'(i * 16'h0101) ^ 16'h5A00;
      exp_mem[i] = 16'(i * 16'h0101) ^ 16'h5A00;
    end
    for (int i = 0; i < 128; i++)
      step(0, 0, 1, 7'(i), 16'h0, "bd_read");

    // Read-during-write is read-first.
    step(0, 1, 0, 7'd5, 16'hAAAA, "rdw_setup");
    step(0, 1, 1, 7'd5, 16'h5555, "rdw_old");
    step(0, 0, 1, 7'd5, 16'h0, "rdw_new");

    // r_data holds with r_en low, including across an unrelated write.
    step(0, 1, 0, 7'd9, 16'h1234, "hold_setup");
    step(0, 0, 1, 7'd9, 16'h0, "hold_read");
    step(0, 0, 0, 7'd9, 16'h0, "hold");
    step(0, 0, 0, 7'd3, 16'h0, "hold");
    step(0, 1, 0, 7'd10, 16'hBEEF, "hold_wr");
    step(0, 0, 0, 7'd0, 16'hFFFF, "hold");

    // Reset asserted mid write burst: write to 30 is dropped, earlier writes survive.
    for (int i = 20; i < 30; i++)
      step(0, 1, 0, 7'(i), 16'hC000 + 16'(i), "burst_hold");
    step(1, 1, 1, 7'd30, 16'hDEAD, "midrst");
    step(1, 0, 0, 7'd31, 16'h0, "midrst");
    for (int i = 20; i <= 30; i++)
      step(0, 0, 1, 7'(i), 16'h0, "post_rst_read");
    step(0, 0, 1, 7'd10, 16'h0, "post_rst_read");
    drain();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
